// File: rtl/window_fetch.sv
// ---------------------------------------------------------------------------
// window_fetch
//
// Walks a 3x3 neighbourhood window over an IMG_W x IMG_H image in serpentine
// order. For every window centre it fetches the missing pixels from memory,
// streams them into the consumer's window register file (pix_valid/pix_slot/
// pix_data), commands window shifts (start_shift/shift_direc) and hands the
// finished window over with win_ready/win_ack.
//
// Ports
//   clk          sole clock, rising edge
//   n_rst        synchronous, active-low reset
//   start        one-cycle request to scan a frame (ignored while busy)
//   mem_ren      one-cycle pixel read strobe
//   mem_addr     pixel address y*IMG_W+x, valid with mem_ren
//   mem_rvalid   read data return strobe (latency >= 1 cycle)
//   mem_rdata    returned pixel
//   start_shift  one-cycle window shift command
//   shift_direc  01 left, 10 right, 11 down, 00 idle
//   pix_valid    write pix_data into window slot pix_slot
//   pix_slot     window slot 0..8, slot = 3*col + r
//   pix_data     registered copy of mem_rdata
//   win_ready    window for the current centre is complete
//   win_ack      consumer accepts the window (only looked at with win_ready)
//   busy         scan in progress
//   done         one-cycle pulse after the last window is accepted
//   win_count    (only with WINDOW_FETCH_CNT_EN) accepted windows this frame
//
// Optional feature: define WINDOW_FETCH_CNT_EN to add the win_count output.
// ---------------------------------------------------------------------------
module window_fetch #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    output logic              pix_valid,
    output logic [3:0]        pix_slot,
    output logic [7:0]        pix_data,
    output logic              win_ready,
    input  logic              win_ack,
    output logic              busy,
    output logic              done
`ifdef WINDOW_FETCH_CNT_EN
    ,
    output logic [ADDR_W-1:0] win_count
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_LOAD3     = 3'd4;
    localparam logic [2:0] S_FIN       = 3'd5;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cx;
    logic [ADDR_W-1:0] cy;
    // cy*IMG_W, kept incrementally so no multiplier is needed
    logic [ADDR_W-1:0] row_base;
    // 1 while the current pass moves x upward
    logic              fwd;
    // direction of the last shift, selects which slots LOAD3 refills
    logic [1:0]        load_dir;
    logic [3:0]        issue_cnt;
    logic              pending;
    logic [3:0]        pend_slot;

    logic              in_load;
    logic [3:0]        load_total;
    logic              issued_all;
    logic              can_issue;
    logic              load_done;
    logic [3:0]        rd_slot;
    logic [1:0]        rd_col;
    logic [1:0]        rd_row;
    logic [ADDR_W-1:0] rd_x;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_addr;
    logic              row_end;
    logic              last_win;
    logic [1:0]        next_dir;

    assign busy      = (state != S_IDLE) && (state != S_FIN);
    assign done      = (state == S_FIN);
    assign win_ready = (state == S_WAIT_ACK);

    assign in_load    = (state == S_INIT_LOAD) || (state == S_LOAD3);
    assign load_total = (state == S_INIT_LOAD) ? 4'd9 : 4'd3;
    assign issued_all = (issue_cnt == load_total);

    // A new read may go out in the same cycle the previous one returns, so
    // mem_ren lands in the cycle right after mem_rvalid at the earliest.
    assign can_issue = in_load && !issued_all && (!pending || mem_rvalid);

    // Leaving one cycle after the last return means the final pix_valid has
    // already been presented before win_ready rises.
    assign load_done = in_load && issued_all && !pending;

    assign row_end  = fwd ? (cx == LAST_X) : (cx == ONE);
    assign last_win = row_end && (cy == LAST_Y);
    assign next_dir = row_end ? DIR_DOWN : (fwd ? DIR_LEFT : DIR_RIGHT);

    // Slot of the next read: all nine in order for a fresh window, otherwise
    // the three slots that the last shift vacated.
    always_comb begin
        rd_slot = issue_cnt;
        if (state == S_LOAD3) begin
            case (load_dir)
                DIR_LEFT:  rd_slot = 4'd6 + issue_cnt;
                DIR_RIGHT: rd_slot = issue_cnt;
                DIR_DOWN: begin
                    case (issue_cnt)
                        4'd0:    rd_slot = 4'd0;
                        4'd1:    rd_slot = 4'd3;
                        default: rd_slot = 4'd6;
                    endcase
                end
                default:   rd_slot = issue_cnt;
            endcase
        end
    end

    // Split the slot into window column and row (slot = 3*col + r) with a
    // lookup instead of a divider.
    always_comb begin
        rd_col = 2'd0;
        rd_row = 2'd0;
        case (rd_slot)
            4'd0: begin rd_col = 2'd0; rd_row = 2'd0; end
            4'd1: begin rd_col = 2'd0; rd_row = 2'd1; end
            4'd2: begin rd_col = 2'd0; rd_row = 2'd2; end
            4'd3: begin rd_col = 2'd1; rd_row = 2'd0; end
            4'd4: begin rd_col = 2'd1; rd_row = 2'd1; end
            4'd5: begin rd_col = 2'd1; rd_row = 2'd2; end
            4'd6: begin rd_col = 2'd2; rd_row = 2'd0; end
            4'd7: begin rd_col = 2'd2; rd_row = 2'd1; end
            default: begin rd_col = 2'd2; rd_row = 2'd2; end
        endcase
    end

    // Row r = 0 is the row below the centre (y+1), r = 2 the row above.
    always_comb begin
        rd_x = cx + ADDR_W'(rd_col) - ONE;
        case (rd_row)
            2'd0:    rd_base = row_base + W_STEP;
            2'd1:    rd_base = row_base;
            default: rd_base = row_base - W_STEP;
        endcase
        rd_addr = rd_base + rd_x;
    end

    // Main sequencer: read issue/return tracking plus the scan state machine.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            cx          <= '0;
            cy          <= '0;
            row_base    <= '0;
            fwd         <= 1'b0;
            load_dir    <= DIR_NONE;
            issue_cnt   <= '0;
            pending     <= 1'b0;
            pend_slot   <= '0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
            start_shift <= 1'b0;
            shift_direc <= DIR_NONE;
            pix_valid   <= 1'b0;
            pix_slot    <= '0;
            pix_data    <= '0;
        end else begin
            mem_ren     <= 1'b0;
            start_shift <= 1'b0;
            shift_direc <= DIR_NONE;

            // Returns are only honoured for a read we actually issued, which
            // also drops stray strobes in IDLE and FIN.
            pix_valid <= pending && mem_rvalid;
            if (pending && mem_rvalid) begin
                pix_slot <= pend_slot;
                pix_data <= mem_rdata;
            end

            if (can_issue) begin
                mem_ren   <= 1'b1;
                mem_addr  <= rd_addr;
                pending   <= 1'b1;
                pend_slot <= rd_slot;
                issue_cnt <= issue_cnt + 4'd1;
            end else if (mem_rvalid) begin
                pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_INIT_LOAD;
                        cx        <= ONE;
                        cy        <= ONE;
                        row_base  <= W_STEP;
                        fwd       <= 1'b1;
                        issue_cnt <= '0;
                    end
                end
                S_INIT_LOAD, S_LOAD3: begin
                    if (load_done) begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (win_ack) begin
                        if (last_win) begin
                            state <= S_FIN;
                        end else begin
                            state       <= S_SHIFT;
                            start_shift <= 1'b1;
                            shift_direc <= next_dir;
                            load_dir    <= next_dir;
                        end
                    end
                end
                S_SHIFT: begin
                    case (load_dir)
                        DIR_LEFT:  cx <= cx + ONE;
                        DIR_RIGHT: cx <= cx - ONE;
                        DIR_DOWN: begin
                            cy       <= cy + ONE;
                            row_base <= row_base + W_STEP;
                            fwd      <= ~fwd;
                        end
                        default: cx <= cx;
                    endcase
                    issue_cnt <= '0;
                    state     <= S_LOAD3;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef WINDOW_FETCH_CNT_EN
    // Accepted-window counter, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            win_count <= '0;
        end else if ((state == S_IDLE) && start) begin
            win_count <= '0;
        end else if ((state == S_WAIT_ACK) && win_ack) begin
            win_count <= win_count + ONE;
        end
    end
`endif

endmodule
